// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register pipeline: opcode and FSM state encodings.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/instr_register_pipe_alu.sv
// Combinational ALU for the load pipeline's write stage (module instr_alu).
// INSTR_REG_SATURATE_EN selects clamping instead of wrapping when narrowing the result.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = 32,
  parameter int RES_WIDTH = 64
) (
  input  opcode_t                     opcode,
  input  logic signed [OP_WIDTH-1:0]  operand_a,
  input  logic signed [OP_WIDTH-1:0]  operand_b,
  output logic signed [RES_WIDTH-1:0] result,
  output logic                        error
);

  localparam int WW = 2 * OP_WIDTH;

  logic signed [WW-1:0] a_w;
  logic signed [WW-1:0] b_w;
  logic signed [WW-1:0] wide;
  logic                 b_zero;

  // Double-width operands make MULT exact and keep MIN/-1 from overflowing.
  assign a_w    = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
  assign b_w    = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
  assign b_zero = (operand_b == '0);

  always_comb begin
    wide  = '0;
    error = 1'b0;
    case (opcode)
      ZERO:  wide = '0;
      PASSA: wide = a_w;
      PASSB: wide = b_w;
      ADD:   wide = a_w + b_w;
      SUB:   wide = a_w - b_w;
      MULT:  wide = a_w * b_w;
      DIV: begin
        if (b_zero) error = 1'b1;
        else        wide  = a_w / b_w;
      end
      MOD: begin
        if (b_zero) error = 1'b1;
        else        wide  = a_w % b_w;
      end
      default: wide = '0;
    endcase
  end

`ifdef INSTR_REG_SATURATE_EN
  logic signed [WW-1:0] res_max;
  logic signed [WW-1:0] res_min;

  assign res_max = {{(WW-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
  assign res_min = {{(WW-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

  always_comb begin
    if (wide > res_max)      result = res_max[RES_WIDTH-1:0];
    else if (wide < res_min) result = res_min[RES_WIDTH-1:0];
    else                     result = wide[RES_WIDTH-1:0];
  end
`else
  assign result = wide[RES_WIDTH-1:0];
`endif

endmodule

// File: rtl/instr_register_pipe.sv
// Instruction register file with a two-stage load pipeline, registered read port and
// sequenced bulk clear. Result narrowing is set by INSTR_REG_SATURATE_EN (see instr_alu).
//
// state | meaning
// RUN   | loads accepted, clear_req honoured
// DRAIN | loads blocked, waiting for the in-flight load to land
// CLEAR | zeroing one entry per cycle at clr_idx, then back to RUN
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = 32,
  parameter int RES_WIDTH = 64,
  parameter int DEPTH     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  opcode_t                      opcode,
  input  logic [OP_WIDTH-1:0]          operand_a,
  input  logic [OP_WIDTH-1:0]          operand_b,
  input  logic [$clog2(DEPTH)-1:0]     write_pointer,
  input  logic                         auto_inc,
  input  logic                         clear_req,
  input  logic                         read_en,
  input  logic [$clog2(DEPTH)-1:0]     read_pointer,
  output logic                         read_valid,
  output opcode_t                      rd_opcode,
  output logic [OP_WIDTH-1:0]          rd_operand_a,
  output logic [OP_WIDTH-1:0]          rd_operand_b,
  output logic [RES_WIDTH-1:0]         rd_result,
  output logic                         rd_error,
  output logic                         rd_written,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    opcode_t              op;
    logic [OP_WIDTH-1:0]  a;
    logic [OP_WIDTH-1:0]  b;
    logic [RES_WIDTH-1:0] res;
    logic                 err;
    logic                 written;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  state_t              state_q, state_d;
  logic [AW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]       clr_idx_q, clr_idx_d;
  logic                s1_valid_q, s1_valid_d;
  opcode_t             s1_op_q, s1_op_d;
  logic [OP_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [OP_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [AW-1:0]       s1_addr_q, s1_addr_d;
  logic                read_valid_q, read_valid_d;
  entry_t              rd_q, rd_d;

  logic [RES_WIDTH-1:0] alu_res;
  logic                 alu_err;
  logic                 accept;

  instr_alu #(
    .OP_WIDTH  (OP_WIDTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_alu (
    .opcode    (s1_op_q),
    .operand_a (s1_a_q),
    .operand_b (s1_b_q),
    .result    (alu_res),
    .error     (alu_err)
  );

  // Gated by reset directly so ready is low while reset is held and high the
  // first cycle after it drops, without waiting for another edge.
  assign load_ready = !reset && (state_q == RUN);
  assign busy       = !reset && ((state_q != RUN) || s1_valid_q);
  assign accept     = load_valid && load_ready;

  always_comb begin
    mem_d        = mem_q;
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    clr_idx_d    = clr_idx_q;
    s1_valid_d   = accept;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_addr_d    = s1_addr_q;
    read_valid_d = read_en;
    rd_d         = read_en ? mem_q[read_pointer] : rd_q;

    if (accept) begin
      s1_op_d   = opcode;
      s1_a_d    = operand_a;
      s1_b_d    = operand_b;
      s1_addr_d = auto_inc ? wr_cnt_q : write_pointer;
      if (auto_inc) wr_cnt_d = wr_cnt_q + AW'(1);
    end

    if (s1_valid_q) begin
      mem_d[s1_addr_q] = '{op: s1_op_q, a: s1_a_q, b: s1_b_q, res: alu_res,
                           err: alu_err, written: 1'b1};
    end

    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d   = DRAIN;
          clr_idx_d = '0;
        end
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        mem_d[clr_idx_q] = '0;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d  = RUN;
          wr_cnt_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q      <= RUN;
      wr_cnt_q     <= '0;
      clr_idx_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_op_q      <= ZERO;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_addr_q    <= '0;
      read_valid_q <= 1'b0;
      rd_q         <= '0;
    end else begin
      mem_q        <= mem_d;
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      clr_idx_q    <= clr_idx_d;
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_addr_q    <= s1_addr_d;
      read_valid_q <= read_valid_d;
      rd_q         <= rd_d;
    end
  end

  assign read_valid   = read_valid_q;
  assign rd_opcode    = rd_q.op;
  assign rd_operand_a = rd_q.a;
  assign rd_operand_b = rd_q.b;
  assign rd_result    = rd_q.res;
  assign rd_error     = rd_q.err;
  assign rd_written   = rd_q.written;

endmodule
